// File: rtl/nmea_checksum_framer.sv
// rtl/nmea_checksum_framer.sv - NMEA sentence framer with XOR checksum gate and replay
//
// Purpose: collects one NMEA sentence ('$' + body) from a byte strobe stream,
// checks the two-hex-digit XOR checksum after '*', and replays only valid
// sentences downstream over a valid/ready byte interface. Rejected sentences
// pulse sentence_err and bump a saturating counter.
//
// Ports:
//   sclk, rstn           clock, asynchronous active-low reset
//   rx_valid, rx_data    one-cycle byte strobe from the UART receiver
//   out_valid/out_ready  replay handshake; out_data with out_sof/out_eof markers
//   sentence_ok/_err     one-cycle verdict pulses
//   err_count            saturating count of sentence_err pulses
module nmea_checksum_framer #(
  parameter int MAX_LEN = 80,
  parameter int CNT_W   = 16
) (
  input  logic             sclk,
  input  logic             rstn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             sentence_ok,
  output logic             sentence_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic [2:0] {IDLE, COLLECT, CK_HI, CK_LO, REPLAY} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;     // bytes stored, including '$'
  logic [LW-1:0]     rd_q, rd_d;       // replay read pointer
  logic [7:0]        xor_q, xor_d;
  logic [3:0]        hi_q, hi_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        mem_q [MAX_LEN];
  logic              we;
  logic [AW-1:0]     waddr;

  logic [4:0]        hx;               // {valid, nibble}
  logic              last_byte;

  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'b0_0000;
  endfunction

  assign last_byte = (rd_q == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    xor_d   = xor_q;
    hi_d    = hi_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = len_q[AW-1:0];
    hx      = hex_nib(rx_data);

    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == CH_DOLLAR) begin
          we      = 1'b1;
          waddr   = '0;
          len_d   = LW'(1);
          xor_d   = 8'h00;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          if (rx_data == CH_STAR) begin
            state_d = CK_HI;
          end else if (rx_data == CH_DOLLAR) begin
            // Restart on a fresh '$'; the abandoned sentence counts as one error.
            err_d   = 1'b1;
            we      = 1'b1;
            waddr   = '0;
            len_d   = LW'(1);
            xor_d   = 8'h00;
          end else if (rx_data == CH_CR || rx_data == CH_LF) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (len_q == LW'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            we      = 1'b1;
            len_d   = len_q + LW'(1);
            xor_d   = xor_q ^ rx_data;
          end
        end
      end
      CK_HI: begin
        if (rx_valid) begin
          if (hx[4]) begin
            hi_d    = hx[3:0];
            state_d = CK_LO;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CK_LO: begin
        if (rx_valid) begin
          if (hx[4] && {hi_q, hx[3:0]} == xor_q) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = REPLAY;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      REPLAY: begin
        // Single buffer: a new sentence arriving now is an overrun.
        if (rx_valid && rx_data == CH_DOLLAR) err_d = 1'b1;
        if (out_ready) begin
          if (last_byte) state_d = IDLE;
          else           rd_d    = rd_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (err_d && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      rd_q    <= '0;
      xor_q   <= 8'h00;
      hi_q    <= 4'h0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      xor_q   <= xor_d;
      hi_q    <= hi_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (we) mem_q[waddr] <= rx_data;
  end

  assign out_valid    = (state_q == REPLAY);
  assign out_data     = out_valid ? mem_q[rd_q[AW-1:0]] : 8'h00;
  assign out_sof      = out_valid && (rd_q == '0);
  assign out_eof      = out_valid && last_byte;
  assign sentence_ok  = ok_q;
  assign sentence_err = err_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_nmea_checksum_framer.sv
// tb/tb_nmea_checksum_framer.sv - directed table-driven bench for nmea_checksum_framer
module tb_nmea_checksum_framer;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic             sclk = 1'b0;
  logic             rstn = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             out_eof;
  logic             sentence_ok;
  logic             sentence_err;
  logic [CNT_W-1:0] err_count;

  nmea_checksum_framer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .sclk(sclk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .sentence_ok(sentence_ok),
    .sentence_err(sentence_err), .err_count(err_count)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;
  int exp_errs = 0;

  int cyc = 0;
  int ok_seen = 0;
  int err_seen = 0;
  logic [7:0] obs_data [$];
  string      obs_flag [$];
  int         obs_cyc  [$];

  always @(posedge sclk) cyc++;

  always @(negedge sclk) begin
    if (rstn) begin
      if (sentence_ok)  ok_seen++;
      if (sentence_err) err_seen++;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_flag.push_back(out_sof && out_eof ? "B" : out_sof ? "S" : out_eof ? "E" : "-");
        obs_cyc.push_back(cyc);
      end
    end
  end

  typedef struct {
    string s;
    int    ok;
    int    err;
    string out;
    bit    tchk;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, got, exp);
    end
  endtask

  function automatic string exp_flags(input int n);
    string f = "";
    for (int i = 0; i < n; i++) begin
      if (n == 1)          f = {f, "B"};
      else if (i == 0)     f = {f, "S"};
      else if (i == n - 1) f = {f, "E"};
      else                 f = {f, "-"};
    end
    return f;
  endfunction

  function automatic string got_stream();
    string g = "";
    foreach (obs_data[i]) g = $sformatf("%s%c", g, obs_data[i]);
    return g;
  endfunction

  function automatic string got_flags();
    string g = "";
    foreach (obs_flag[i]) g = {g, obs_flag[i]};
    return g;
  endfunction

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic clear_mon();
    ok_seen = 0;
    err_seen = 0;
    obs_data.delete();
    obs_flag.delete();
    obs_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge sclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  initial begin
    vecs.push_back('{s:"$AB*03",        ok:1, err:0, out:"$AB",      tchk:1'b1});
    vecs.push_back('{s:"$AB*04",        ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$AB*0g",        ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$AB$CD*07",     ok:1, err:1, out:"$CD",      tchk:1'b1});
    vecs.push_back('{s:"$ABCDEFGHI*00", ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$AB*03\r\n",    ok:1, err:0, out:"$AB",      tchk:1'b0});
    vecs.push_back('{s:"$*00",          ok:1, err:0, out:"$",        tchk:1'b1});
    vecs.push_back('{s:"$Z*5a",         ok:1, err:0, out:"$Z",       tchk:1'b1});
    vecs.push_back('{s:"$Z*5A",         ok:1, err:0, out:"$Z",       tchk:1'b1});
    vecs.push_back('{s:"$A\rB*03",      ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$ABCDEFG*40",   ok:1, err:0, out:"$ABCDEFG", tchk:1'b1});
    vecs.push_back('{s:"$AB*G3",        ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$AB*05",        ok:0, err:1, out:"",         tchk:1'b0});
    vecs.push_back('{s:"$X*00",         ok:0, err:1, out:"",         tchk:1'b0});

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ok", sentence_ok, 0);
    chk("rst_err", sentence_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_sof_eof", {out_sof, out_eof}, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge sclk); #1;
    rstn = 1'b1;
    idle(2);

    // Backpressure: 'A' held for 5 cycles after the '$' transfer
    clear_mon();
    out_ready = 1'b1;
    send_str("$AB*03");
    chk("hold_ok_pulse", {sentence_ok, out_valid, out_sof}, 3'b111);
    idle(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h41);
      chk("hold_flags", {out_sof, out_eof}, 2'b00);
      idle(1);
    end
    out_ready = 1'b1;
    idle(6);
    chk_str("hold_stream", got_stream(), "$AB");
    chk_str("hold_flags_seq", got_flags(), "S-E");
    chk("hold_err_count", err_count, sat(exp_errs));

    // Overrun: a '$' during replay is dropped and counted
    clear_mon();
    out_ready = 1'b0;
    send_str("$AB*03");
    chk("ovr_ok", sentence_ok, 1);
    idle(2);
    send_byte(8'h24);
    exp_errs++;
    chk("ovr_err_pulse", sentence_err, 1);
    chk("ovr_still_valid", {out_valid, out_data}, {1'b1, 8'h24});
    send_str("CD*07");
    out_ready = 1'b1;
    idle(6);
    send_str("CD*07");
    idle(6);
    chk_str("ovr_stream", got_stream(), "$AB");
    chk("ovr_ok_count", ok_seen, 1);
    chk("ovr_err_count_pulses", err_seen, 1);
    chk("ovr_err_count", err_count, sat(exp_errs));

    // Table of sentences with out_ready held high
    foreach (vecs[v]) begin
      clear_mon();
      out_ready = 1'b1;
      send_str(vecs[v].s);
      if (vecs[v].tchk)
        chk($sformatf("v%0d_ok_timing", v), {sentence_ok, out_valid, out_sof}, 3'b111);
      idle(14);
      exp_errs += vecs[v].err;
      chk($sformatf("v%0d_ok", v), ok_seen, vecs[v].ok);
      chk($sformatf("v%0d_err", v), err_seen, vecs[v].err);
      chk_str($sformatf("v%0d_stream", v), got_stream(), vecs[v].out);
      chk_str($sformatf("v%0d_flags", v), got_flags(), exp_flags(vecs[v].out.len()));
      if (obs_cyc.size() > 1)
        chk($sformatf("v%0d_back_to_back", v), obs_cyc[obs_cyc.size()-1] - obs_cyc[0],
            obs_cyc.size() - 1);
      chk($sformatf("v%0d_err_count", v), err_count, sat(exp_errs));
      chk($sformatf("v%0d_idle_after", v), out_valid, 0);
    end

    // Asynchronous reset mid-replay, then an empty-body sentence
    clear_mon();
    out_ready = 1'b1;
    send_str("$AB*03");
    idle(1);
    chk("rr_mid_replay", {out_valid, out_data}, {1'b1, 8'h41});
    #2;
    rstn = 1'b0;
    #1;
    chk("rr_valid_drop", out_valid, 0);
    chk("rr_err_count", err_count, 0);
    exp_errs = 0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    clear_mon();
    send_str("$*00");
    chk("rr_ok_timing", {sentence_ok, out_valid, out_sof, out_eof, out_data}, {4'b1111, 8'h24});
    idle(6);
    chk_str("rr_stream", got_stream(), "$");
    chk_str("rr_flags", got_flags(), "B");
    chk("rr_err_count_final", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
